wb_stage: RTL

Write-back stage of the ARM pipeline. Accepts completed instructions from the memory stage over a valid/ready handshake and waits on the data-memory controller for load data. It drives the register-file write port (`Dest_wb`, `Result_WB`, `writeBackEn`) and keeps a running count of retired instructions. It is the only producer of register-file writes.

---
 rtl/arm_pkg.sv | 18 +
 rtl/wb_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: register index type, PC index,
// write-back FSM state encoding and datapath word width.
package arm_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned REG_IDX_W = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // R15 lives in the fetch unit, not in the register file.
    localparam reg_idx_t REG_PC = 4'hF;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } wb_state_t;

endpackage : arm_pkg

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the ARM pipeline.
//
// Accepts retiring instructions from the memory stage (valid/ready), waits
// for load data from the data-memory controller, drives the register-file
// write port and counts retired instructions.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; stall_out = ~in_ready
//   in_wb_en, in_mem_r_en instruction writes a register / is a load
//   in_dest, in_alu_result destination index and ALU result
//   mem_rdata(_valid)     load data return
//   Dest_wb, Result_WB, writeBackEn  register-file write port
//   retire_count          retired-instruction counter (wraps)
//   pc_wr_err             sticky: a write to R15 was suppressed
//
// Optional build macro WB_FWD_EN adds forwarding outputs for the hazard unit:
//   fwd_pend_valid, fwd_pend_dest, fwd_wb_valid, fwd_wb_dest, fwd_wb_value.
module wb_stage
    import arm_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_wb_en,
    input  logic                 in_mem_r_en,
    input  logic [REG_IDX_W-1:0] in_dest,
    input  logic [WORD_W-1:0]    in_alu_result,
    input  logic [WORD_W-1:0]    mem_rdata,
    input  logic                 mem_rdata_valid,
    output logic [REG_IDX_W-1:0] Dest_wb,
    output logic [WORD_W-1:0]    Result_WB,
    output logic                 writeBackEn,
    output logic                 stall_out,
    output logic [CNT_W-1:0]     retire_count,
    output logic                 pc_wr_err
`ifdef WB_FWD_EN
    ,
    output logic                 fwd_pend_valid,
    output logic [REG_IDX_W-1:0] fwd_pend_dest,
    output logic                 fwd_wb_valid,
    output logic [REG_IDX_W-1:0] fwd_wb_dest,
    output logic [WORD_W-1:0]    fwd_wb_value
`endif
);

    wb_state_t      state_q,   state_d;
    reg_idx_t       pend_q,    pend_d;
    reg_idx_t       dest_q,    dest_d;
    logic [WORD_W-1:0] res_q,  res_d;
    logic           we_q,      we_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic           err_q,     err_d;

    // Write request raised by the FSM this cycle, resolved against R15 below.
    logic              wr_req_c;
    reg_idx_t          wr_dest_c;
    logic [WORD_W-1:0] wr_data_c;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            dest_q  <= '0;
            res_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dest_q  <= dest_d;
            res_q   <= res_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, retire and write-port logic.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        dest_d    = dest_q;
        res_d     = res_q;
        we_d      = 1'b0;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wr_req_c  = 1'b0;
        wr_dest_c = '0;
        wr_data_c = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mem_r_en) begin
                        // Every load writes; in_wb_en is not consulted.
                        state_d = WAIT_DATA;
                        pend_d  = in_dest;
                    end else begin
                        // ALU ops retire at acceptance, writing or not.
                        cnt_d     = cnt_q + CNT_W'(1);
                        wr_req_c  = in_wb_en;
                        wr_dest_c = in_dest;
                        wr_data_c = in_alu_result;
                    end
                end
            end
            WAIT_DATA: begin
                if (mem_rdata_valid) begin
                    state_d   = IDLE;
                    pend_d    = '0;
                    cnt_d     = cnt_q + CNT_W'(1);
                    wr_req_c  = 1'b1;
                    wr_dest_c = pend_q;
                    wr_data_c = mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase

        // R15 is not in the register file: drop the write, flag it, keep the
        // previous write-port values.
        if (wr_req_c) begin
            if (wr_dest_c == REG_PC) begin
                err_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                dest_d = wr_dest_c;
                res_d  = wr_data_c;
            end
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign stall_out    = (state_q == WAIT_DATA);
    assign Dest_wb      = dest_q;
    assign Result_WB    = res_q;
    assign writeBackEn  = we_q;
    assign retire_count = cnt_q;
    assign pc_wr_err    = err_q;

`ifdef WB_FWD_EN
    // pend_q is cleared whenever no load is outstanding.
    assign fwd_pend_valid = (state_q == WAIT_DATA);
    assign fwd_pend_dest  = pend_q;
    assign fwd_wb_valid   = we_q;
    assign fwd_wb_dest    = dest_q;
    assign fwd_wb_value   = res_q;
`endif

endmodule : wb_stage
